// File: rtl/stream_arbiter_multiplexer.sv
// N-to-1 packet-aware stream multiplexer with a registered output stage.
// A source is chosen by round-robin arbitration or by control_signals, and
// keeps the grant until the beat carrying in_last has been transferred.
//
// Handshake: a beat moves on any interface when valid && ready are both high
// in the same cycle. Valid never waits on ready. in_ready is one-hot or zero.
// It is a function of state, in_valid, control_signals and out_ready, and it
// never feeds back into itself.
module stream_arbiter_multiplexer #(
  parameter int NUM_OF_CONTROL_SIGNALS = 2,
  parameter int WIDTH                  = 32,
  parameter int ROUND_ROBIN            = 1,
  localparam int N  = 2 ** NUM_OF_CONTROL_SIGNALS,
  localparam int SW = (NUM_OF_CONTROL_SIGNALS > 0) ? NUM_OF_CONTROL_SIGNALS : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SW-1:0]    control_signals,
  input  logic [N-1:0]     in_valid,
  input  logic [N-1:0]     in_last,
  input  logic [WIDTH-1:0] in_data [N-1:0],
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic             out_last,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_source,
  input  logic             out_ready,
  output logic             dbg_state_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q;
  logic [SW-1:0]    lock_src_q;
  logic [SW-1:0]    rr_ptr_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SW-1:0]    out_source_q;

  logic             can_load;
  logic [SW-1:0]    rr_win;
  logic             rr_found;
  logic [SW-1:0]    rr_idx;
  logic [SW-1:0]    cand;
  logic             cand_valid;
  logic             grant;

  // The output register can take a new beat when empty or being drained.
  assign can_load = !out_valid_q || out_ready;

  // Round-robin search: first valid source upward from rr_ptr+1, wrapping.
  // With N a power of two, SW-bit arithmetic provides the wrap for free.
  always_comb begin
    rr_win   = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    if (N == 1) begin
      rr_found = in_valid[0];
    end else begin
      for (int i = 0; i < N; i++) begin
        rr_idx = rr_ptr_q + SW'(1) + SW'(i);
        if (!rr_found && in_valid[rr_idx]) begin
          rr_found = 1'b1;
          rr_win   = rr_idx;
        end
      end
    end
  end

  // Candidate selection: locked source mid-packet, otherwise the arbiter's pick.
  // In fixed mode an invalid selected source is not skipped.
  always_comb begin
    cand       = '0;
    cand_valid = 1'b0;
    if (state_q == LOCKED) begin
      cand       = lock_src_q;
      cand_valid = in_valid[lock_src_q];
    end else if (ROUND_ROBIN != 0) begin
      cand       = rr_win;
      cand_valid = rr_found;
    end else if (N > 1) begin
      cand       = control_signals;
      cand_valid = in_valid[control_signals];
    end else begin
      cand_valid = in_valid[0];
    end
  end

  // Reset gates the grant so no source is readied while the block is held.
  assign grant = cand_valid && can_load && !reset;

  // One-hot ready to the granted source only.
  always_comb begin
    in_ready = '0;
    if (grant) begin
      in_ready[cand] = 1'b1;
    end
  end

  // Packet FSM, arbitration pointer and output register in one sequential block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lock_src_q   <= '0;
      rr_ptr_q     <= SW'(N - 1);
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_source_q <= '0;
    end else begin
      if (grant) begin
        out_valid_q  <= 1'b1;
        out_last_q   <= in_last[cand];
        out_data_q   <= in_data[cand];
        out_source_q <= cand;
        if (in_last[cand]) begin
          // Packet done: the next arbitration starts just past this source.
          state_q  <= IDLE;
          rr_ptr_q <= cand;
        end else begin
          state_q    <= LOCKED;
          lock_src_q <= cand;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_data    = out_data_q;
  assign out_source  = out_source_q;
  assign dbg_state_o = logic'(state_q);

endmodule

// File: tb/tb_stream_arbiter_multiplexer.sv
// Directed bench for stream_arbiter_multiplexer: one round-robin instance and
// one fixed-selection instance share clock, reset and the input streams.
module tb_stream_arbiter_multiplexer;

  localparam int C = 2;
  localparam int N = 4;
  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [C-1:0] ctrl;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_last;
  logic [W-1:0] in_data [N-1:0];
  logic         out_ready;

  logic [N-1:0] rr_in_ready;
  logic         rr_out_valid, rr_out_last, rr_dbg;
  logic [W-1:0] rr_out_data;
  logic [C-1:0] rr_out_source;

  logic [N-1:0] fx_in_ready;
  logic         fx_out_valid, fx_out_last, fx_dbg;
  logic [W-1:0] fx_out_data;
  logic [C-1:0] fx_out_source;

  int checks = 0;
  int errors = 0;

  stream_arbiter_multiplexer #(.NUM_OF_CONTROL_SIGNALS(C), .WIDTH(W), .ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .reset(reset), .control_signals(ctrl),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_last(rr_out_last),
    .out_data(rr_out_data), .out_source(rr_out_source), .out_ready(out_ready),
    .dbg_state_o(rr_dbg)
  );

  stream_arbiter_multiplexer #(.NUM_OF_CONTROL_SIGNALS(C), .WIDTH(W), .ROUND_ROBIN(0)) dut_fx (
    .clk(clk), .reset(reset), .control_signals(ctrl),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(fx_in_ready), .out_valid(fx_out_valid), .out_last(fx_out_last),
    .out_data(fx_out_data), .out_source(fx_out_source), .out_ready(out_ready),
    .dbg_state_o(fx_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid  = '0;
    in_last   = '0;
    ctrl      = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i] = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset    = 1'b1;
    in_valid = 4'hF;
    in_last  = 4'hF;
    for (int i = 0; i < N; i++) in_data[i] = W'(i);
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", rr_out_valid); end
      checks++;
      if (rr_out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", rr_out_data); end
      checks++;
      if (rr_in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", rr_in_ready); end
      checks++;
      if (rr_out_last !== 1'b0 || rr_out_source !== 2'd0 || rr_dbg !== 1'b0) begin
        errors++; $display("FAIL reset_misc last %0b src %0d state %0b want 0 0 0", rr_out_last, rr_out_source, rr_dbg);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rr_in_ready !== 4'b0001) begin errors++; $display("FAIL post_reset_ready got %b want 0001", rr_in_ready); end
    step();
    checks++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 32'd0 || rr_out_source !== 2'd0) begin
      errors++; $display("FAIL first_beat got v%0b d%h s%0d want v1 d0 s0", rr_out_valid, rr_out_data, rr_out_source);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    in_valid = 4'hF;
    in_last  = 4'hF;
    for (int i = 0; i < N; i++) in_data[i] = W'(i);
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_data !== W'(k % 4) || rr_out_source !== C'(k % 4)) begin
        errors++; $display("FAIL rr_beat%0d got v%0b d%0d s%0d want v1 d%0d s%0d", k, rr_out_valid, rr_out_data, rr_out_source, k % 4, k % 4);
      end
      checks++;
      if (rr_in_ready !== 4'(1 << ((k + 1) % 4))) begin
        errors++; $display("FAIL rr_ready%0d got %b want %b", k, rr_in_ready, 4'(1 << ((k + 1) % 4)));
      end
    end
  endtask

  task automatic test_packet_lock();
    apply_reset();
    in_valid   = 4'b0010;
    in_last    = 4'b0010;
    in_data[1] = 32'h11;
    step();
    checks++;
    if (rr_out_data !== 32'h11 || rr_out_source !== 2'd1) begin
      errors++; $display("FAIL lock_warmup got d%h s%0d want d11 s1", rr_out_data, rr_out_source);
    end
    in_valid   = 4'b0110;
    in_last    = 4'b0010;
    in_data[1] = 32'h12;
    in_data[2] = 32'hA0;
    for (int b = 0; b < 3; b++) begin
      in_data[2] = 32'hA0 + W'(b);
      in_last[2] = (b == 2);
      #1;
      checks++;
      if (rr_in_ready !== 4'b0100) begin errors++; $display("FAIL lock_ready%0d got %b want 0100", b, rr_in_ready); end
      step();
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_data !== 32'hA0 + W'(b) || rr_out_source !== 2'd2 || rr_out_last !== (b == 2)) begin
        errors++; $display("FAIL lock_beat%0d got v%0b d%h s%0d l%0b want v1 d%h s2 l%0b", b, rr_out_valid, rr_out_data, rr_out_source, rr_out_last, 32'hA0 + W'(b), (b == 2));
      end
    end
    in_valid = 4'b0010;
    #1;
    checks++;
    if (rr_in_ready !== 4'b0010) begin errors++; $display("FAIL lock_next_ready got %b want 0010", rr_in_ready); end
    step();
    checks++;
    if (rr_out_data !== 32'h12 || rr_out_source !== 2'd1) begin
      errors++; $display("FAIL lock_next_src got d%h s%0d want d12 s1", rr_out_data, rr_out_source);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    in_valid   = 4'b1000;
    in_last    = 4'b1000;
    in_data[3] = 32'h30;
    step();
    checks++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 32'h30) begin
      errors++; $display("FAIL bp_first got v%0b d%h want v1 d30", rr_out_valid, rr_out_data);
    end
    out_ready  = 1'b0;
    in_data[3] = 32'h31;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (rr_in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d got %b want 0000", k, rr_in_ready); end
      step();
      checks++;
      if (rr_out_valid !== 1'b1 || rr_out_data !== 32'h30 || rr_out_source !== 2'd3) begin
        errors++; $display("FAIL bp_hold%0d got v%0b d%h s%0d want v1 d30 s3", k, rr_out_valid, rr_out_data, rr_out_source);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (rr_in_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b want 1000", rr_in_ready); end
    step();
    checks++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 32'h31) begin
      errors++; $display("FAIL bp_next got v%0b d%h want v1 d31", rr_out_valid, rr_out_data);
    end
    in_valid = 4'b0000;
    step();
    checks++;
    if (rr_out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got v%0b want 0", rr_out_valid); end
  endtask

  task automatic test_fixed_mode();
    apply_reset();
    ctrl       = 2'd1;
    in_valid   = 4'b1010;
    in_last    = 4'b1000;
    in_data[1] = 32'hB0;
    in_data[3] = 32'h33;
    #1;
    checks++;
    if (fx_in_ready !== 4'b0010) begin errors++; $display("FAIL fx_ready0 got %b want 0010", fx_in_ready); end
    step();
    checks++;
    if (fx_out_data !== 32'hB0 || fx_out_source !== 2'd1 || fx_dbg !== 1'b1) begin
      errors++; $display("FAIL fx_beat0 got d%h s%0d st%0b want dB0 s1 st1", fx_out_data, fx_out_source, fx_dbg);
    end
    ctrl       = 2'd3;
    in_data[1] = 32'hB1;
    in_last    = 4'b1010;
    #1;
    checks++;
    if (fx_in_ready !== 4'b0010) begin errors++; $display("FAIL fx_locked_ready got %b want 0010", fx_in_ready); end
    step();
    checks++;
    if (fx_out_data !== 32'hB1 || fx_out_source !== 2'd1 || fx_out_last !== 1'b1) begin
      errors++; $display("FAIL fx_beat1 got d%h s%0d l%0b want dB1 s1 l1", fx_out_data, fx_out_source, fx_out_last);
    end
    in_valid = 4'b1000;
    #1;
    checks++;
    if (fx_in_ready !== 4'b1000) begin errors++; $display("FAIL fx_switch_ready got %b want 1000", fx_in_ready); end
    step();
    checks++;
    if (fx_out_data !== 32'h33 || fx_out_source !== 2'd3) begin
      errors++; $display("FAIL fx_next got d%h s%0d want d33 s3", fx_out_data, fx_out_source);
    end
    ctrl = 2'd2;
    #1;
    checks++;
    if (fx_in_ready !== 4'b0000) begin errors++; $display("FAIL fx_no_skip got %b want 0000", fx_in_ready); end
    step();
    checks++;
    if (fx_out_valid !== 1'b0) begin errors++; $display("FAIL fx_idle got v%0b want 0", fx_out_valid); end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    in_valid   = 4'b0011;
    in_last    = 4'b0010;
    in_data[0] = 32'hC0;
    in_data[1] = 32'h51;
    step();
    in_data[0] = 32'hC1;
    step();
    checks++;
    if (rr_out_data !== 32'hC1 || rr_out_source !== 2'd0 || rr_dbg !== 1'b1) begin
      errors++; $display("FAIL mid_beat2 got d%h s%0d st%0b want dC1 s0 st1", rr_out_data, rr_out_source, rr_dbg);
    end
    reset      = 1'b1;
    in_data[0] = 32'hC2;
    step();
    checks++;
    if (rr_out_valid !== 1'b0 || rr_in_ready !== 4'b0000 || rr_dbg !== 1'b0) begin
      errors++; $display("FAIL mid_reset got v%0b r%b st%0b want v0 r0000 st0", rr_out_valid, rr_in_ready, rr_dbg);
    end
    reset      = 1'b0;
    in_data[0] = 32'hD0;
    in_last    = 4'b0011;
    #1;
    checks++;
    if (rr_in_ready !== 4'b0001) begin errors++; $display("FAIL mid_restart_ready got %b want 0001", rr_in_ready); end
    step();
    checks++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 32'hD0 || rr_out_source !== 2'd0 || rr_out_last !== 1'b1) begin
      errors++; $display("FAIL mid_restart got v%0b d%h s%0d l%0b want v1 dD0 s0 l1", rr_out_valid, rr_out_data, rr_out_source, rr_out_last);
    end
    step();
    checks++;
    if (rr_out_data !== 32'h51 || rr_out_source !== 2'd1) begin
      errors++; $display("FAIL mid_after got d%h s%0d want d51 s1", rr_out_data, rr_out_source);
    end
  endtask

  // Test sequence and final report
  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_fixed_mode();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_arbiter_multiplexer.md
# stream_arbiter_multiplexer

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes on every input and on the output, for the communications processor datapath. It selects between 2**NUM_OF_CONTROL_SIGNALS input streams either by an externally driven select or by internal round-robin arbitration. A selected source holds the grant for a whole packet, delimited by a last flag. The output is registered so that chains of multiplexers close timing.

## Interface
- NUM_OF_CONTROL_SIGNALS, 2: select width; number of inputs N = 2**NUM_OF_CONTROL_SIGNALS (must be ≥1).
- WIDTH, 32: data bits per beat.
- ROUND_ROBIN, 1: 1 = internal round-robin arbitration; 0 = fixed selection by control_signals.

- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- control_signals  input  NUM_OF_CONTROL_SIGNALS  source select; used only when ROUND_ROBIN=0.
- in_valid  input  N  per-source beat valid.
- in_last  input  N  per-source last beat of packet (qualified by in_valid).
- in_data  input  WIDTH x N (unpacked array [N-1:0])  per-source data.
- in_ready  output  N  per-source accept; at most one bit high in any cycle.
- out_valid  output  1  registered output beat valid.
- out_last  output  1  registered last flag.
- out_data  output  WIDTH  registered data.
- out_source  output  NUM_OF_CONTROL_SIGNALS  index of the source that supplied out_data.
- out_ready  input  1  downstream accept.

## Operation
- Transfer on any interface: valid && ready in the same cycle.
- Output register "can load": !out_valid || out_ready.
- State machine, 2 states:
  - IDLE: candidate = arbitration winner. If candidate's in_valid=1 and can load, then in_ready[candidate]=1 and the beat is loaded. If in_last=0, go to LOCKED with lock_src=candidate; if in_last=1, stay in IDLE.
  - LOCKED: only lock_src is considered. in_ready[lock_src] = can load. Other sources are never readied. A transfer with in_last=1 returns to IDLE.
- Arbitration, ROUND_ROBIN=1: winner is the first valid source searching upward from (rr_ptr+1) mod N with wrap-around. With no valid source, no grant. rr_ptr updates to the winning source on the transfer of the last beat of each packet, including single-beat packets.
- Arbitration, ROUND_ROBIN=0: winner = control_signals, sampled in IDLE only. Changes to control_signals while LOCKED are ignored until the packet ends. Invalid sources at the selected index are not skipped: no grant.
- Output register load: out_data/out_last/out_source take the accepted beat; out_valid=1. If out_ready=1 and no new beat loads, out_valid=0 next cycle. out_data holds its value when not loading.
- in_ready is combinational from state, in_valid, control_signals and out_ready. It never depends on in_ready itself, so there is no loop.
- N=1: source 0 always wins; arbitration logic reduces to a pass-through with register.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, out_source=0, state=IDLE, lock_src=0, rr_ptr=N-1 (source 0 has first priority after reset).
- Reset mid-packet: return to IDLE next edge; any beat in the output register is dropped; no packet resumption.
- Latency: beat accepted in cycle t appears on out_* in cycle t+1.
- Throughput: 1 beat/cycle sustained when out_ready=1, including back-to-back packets from different sources (no idle cycle between packets).
- Backpressure: out_valid=1 && out_ready=0 → out_* stable, all in_ready=0.
- Simultaneous last-beat transfer and new request: the next packet's arbitration happens in the following cycle, using the updated rr_ptr.
- in_valid dropping mid-packet in LOCKED: grant held; the output goes idle until that source resumes.

## Test plan
- Reset then idle: assert reset 2 cycles with all in_valid=1 → out_valid=0, out_data=0, in_ready=0 during reset; first beat from source 0 appears 1 cycle after reset deasserts.
- Round-robin fairness, N=4: all sources continuously send single-beat packets with data = source index, out_ready=1 → out_data sequence 0,1,2,3,0,1… one per cycle, out_source matching.
- Packet lock: source 2 sends a 3-beat packet (0xA0,0xA1,0xA2, last on third beat) while source 1 is valid throughout → out shows A0,A1,A2 contiguously from source 2, then source 3 if valid, else source 1 next.
- Backpressure: out_ready=0 for 4 cycles with a beat held → out_data constant, all in_ready=0; on out_ready=1, next beat follows in the next cycle with no loss or duplication.
- Fixed mode (ROUND_ROBIN=0): control_signals=1, source 1 sends a 2-beat packet; switch control_signals to 3 after the first beat → second beat still from source 1; next packet comes from source 3.
- Reset mid-packet: reset during beat 2 of 4 from source 0 → out_valid=0 next cycle; after reset, arbitration restarts at source 0 as a new packet.
